// File: rtl/image_proc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : image_proc_pkg
//  Description : Shared types and default geometry/arithmetic constants for
//                the image-addition datapath (frame sequencer and its buffer).
//  Revision    : 1.0 - initial release
// ============================================================================
package image_proc_pkg;

    // Default frame geometry and enhanced-sum arithmetic
    localparam int IMG_W_DEF      = 128;
    localparam int IMG_H_DEF      = 128;
    localparam int OFFSET_DEF     = 6;
    localparam int GAIN_NUM_DEF   = 55;
    localparam int GAIN_SHIFT_DEF = 6;
    localparam int OUT_DEPTH_DEF  = 2;

    // Fixed interface widths
    localparam int ADDR_W = 14;
    localparam int PIX_W  = 8;
    localparam int RES_W  = 9;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [RES_W-1:0]  result_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pix_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pix_skid_fifo
//  Description : Small synchronous result buffer with occupancy count and
//                flush. Head entry is presented on data_o while valid_o is
//                high and stays put until popped. A push into a full buffer
//                is accepted only together with a pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_skid_fifo
    import image_proc_pkg::*;
#(
    parameter int DEPTH = OUT_DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  result_t          data_i,
    input  logic             pop_i,
    output result_t          data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    result_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Qualify push/pop against occupancy and form the next count
    always_comb begin
        w_do_pop  = pop_i && (count_q != '0);
        w_do_push = push_i && ((count_q != FULL_CNT) || w_do_pop);
        count_d   = count_q;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy; flush empties without touching storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (w_do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/image_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : image_add_sequencer
//  Description : Frame controller for the image-addition datapath. Issues
//                raster reads to both frame buffers, forms the enhanced-sum
//                pixel ((a+b-OFFSET)*GAIN_NUM >> GAIN_SHIFT, floored at 0) and
//                streams results through a small buffer under valid/ready.
//                Build option CLAMP_8BIT_EN saturates results to 255.
//  Revision    : 1.0 - initial release
// ============================================================================
module image_add_sequencer
    import image_proc_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int OFFSET     = OFFSET_DEF,
    parameter int GAIN_NUM   = GAIN_NUM_DEF,
    parameter int GAIN_SHIFT = GAIN_SHIFT_DEF,
    parameter int OUT_DEPTH  = OUT_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        rd_en,
    output logic [13:0] rd_addr,
    input  logic [7:0]  pix_a,
    input  logic [7:0]  pix_b,
    output logic [8:0]  out_pix,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam int               CNT_W     = $clog2(OUT_DEPTH + 1);
    localparam addr_t            LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(OUT_DEPTH);
    localparam logic [15:0]      OFFSET_W  = 16'(OFFSET);
    localparam logic [15:0]      GAIN_W    = 16'(GAIN_NUM);
    localparam result_t          OFFSET_R  = RES_W'(OFFSET);

    state_t           state_q;
    addr_t            rd_addr_q;
    logic             inflight_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] w_fifo_cnt;
    logic             w_fifo_valid;
    result_t          w_fifo_data;
    logic             w_abort;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W:0]   w_occ;
    logic             w_room;
    logic             w_drained;
    logic [8:0]       w_sum;
    logic [15:0]      w_prod;
    result_t          w_res_full;
    result_t          w_res;

    // Abort only acts on an active frame; in IDLE it merely blocks start
    assign w_abort = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign w_pop   = w_fifo_valid && out_ready;

    // Slots still claimed after this cycle's transfer leaves: buffered plus in flight.
    // Counting the departing entry as free keeps one read per cycle with ready held high.
    assign w_occ  = {1'b0, w_fifo_cnt} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, w_pop};
    assign w_room = (w_occ < DEPTH_LIM);
    assign rd_en  = (state_q == S_RUN) && !w_abort && w_room;

    // Returning data is discarded on abort so nothing from the old frame survives
    assign w_push    = inflight_q && !w_abort;
    assign w_drained = !inflight_q && (w_occ == '0);

    // Enhanced sum: floored at zero below OFFSET, product fits in 16 bits
    assign w_sum      = {1'b0, pix_a} + {1'b0, pix_b};
    assign w_prod     = (16'(w_sum) - OFFSET_W) * GAIN_W;
    assign w_res_full = (w_sum < OFFSET_R) ? '0 : RES_W'(w_prod >> GAIN_SHIFT);

`ifdef CLAMP_8BIT_EN
    assign w_res = (w_res_full > 9'd255) ? 9'd255 : w_res_full;
`else
    assign w_res = w_res_full;
`endif

    pix_skid_fifo #(
        .DEPTH (OUT_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (w_abort),
        .push_i  (w_push),
        .data_i  (w_res),
        .pop_i   (w_pop),
        .data_o  (w_fifo_data),
        .valid_o (w_fifo_valid),
        .count_o (w_fifo_cnt)
    );

    // Frame FSM with address counter, in-flight flag and registered busy/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        state_q   <= S_IDLE;
                        rd_addr_q <= '0;
                        busy_q    <= 1'b0;
                    end else if (rd_en) begin
                        if (rd_addr_q == LAST_ADDR) begin
                            state_q   <= S_DRAIN;
                            rd_addr_q <= '0;
                        end else begin
                            rd_addr_q <= rd_addr_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (w_drained) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_pix   = w_fifo_data;
    assign out_valid = w_fifo_valid;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_image_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_add_sequencer
//  Description : Directed self-checking bench for image_add_sequencer with a
//                behavioural dual frame-buffer model and an output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_add_sequencer;

    localparam int NPIX    = 128 * 128;
    localparam int M_CONST = 0;
    localparam int M_RAMP  = 1;
    localparam int M_MIX   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [7:0]  pix_a = 8'd0;
    logic [7:0]  pix_b = 8'd0;
    logic [8:0]  out_pix;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int   chk_cnt    = 0;
    int   err_cnt    = 0;
    int   cyc        = 0;
    int   t0         = 0;
    int   done_cnt   = 0;
    int   done_c     = 0;
    int   exp_idx    = 0;
    int   mode       = M_CONST;
    int   m_cnt      = 0;
    int   m_infl     = 0;
    int   base_done  = 0;
    int   saved_idx  = 0;
    bit   chk_stall  = 1'b0;
    bit   prev_stall = 1'b0;
    bit   prev_abort = 1'b0;
    bit   pop_n      = 1'b0;
    logic [8:0] prev_pix = 9'd0;

    image_add_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .pix_a     (pix_a),
        .pix_b     (pix_b),
        .out_pix   (out_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Frame-buffer contents for each pattern
    function automatic logic [7:0] pat_a(input int addr);
        case (mode)
            M_CONST: return 8'd100;
            M_RAMP:  return addr[7:0];
            default: case (addr % 4)
                         0:       return 8'd255;
                         1:       return 8'd0;
                         2:       return 8'd4;
                         default: return addr[7:0];
                     endcase
        endcase
    endfunction

    function automatic logic [7:0] pat_b(input int addr);
        case (mode)
            M_CONST: return 8'd100;
            M_RAMP:  return 8'd0;
            default: case (addr % 4)
                         0:       return 8'd255;
                         1:       return 8'd3;
                         2:       return 8'd4;
                         default: return addr[13:6];
                     endcase
        endcase
    endfunction

    function automatic int ref_res(input int a, input int b);
        int s;
        int r;
        s = a + b;
        if (s < 6) return 0;
        r = ((s - 6) * 55) / 64;
`ifdef CLAMP_8BIT_EN
        if (r > 255) r = 255;
`endif
        return r;
    endfunction

    function automatic int exp_val(input int idx);
        if (mode == M_CONST) return 166;
        if (mode == M_MIX) begin
            if (idx % 4 == 0) begin
`ifdef CLAMP_8BIT_EN
                return 255;
`else
                return 433;
`endif
            end
            if (idx % 4 == 1) return 0;
            if (idx % 4 == 2) return 1;
        end
        return ref_res(int'(pat_a(idx)), int'(pat_b(idx)));
    endfunction

    // Both RAMs answer one cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en) begin
            pix_a <= pat_a(int'(rd_addr));
            pix_b <= pat_b(int'(rd_addr));
        end
    end

    // Output scoreboard, done counter, stall-hold and read-gating checks
    always @(negedge clk) begin
        pop_n = out_valid && out_ready;
        if (pop_n) begin
            check_eq("out_pix", int'(out_pix), exp_val(exp_idx));
            exp_idx++;
        end
        if (done) begin
            done_cnt++;
            done_c = cyc - t0 + 1;
        end
        if (chk_stall) begin
            if (prev_stall && !prev_abort) begin
                check_eq("hold_valid", int'(out_valid), 1);
                check_eq("hold_pix", int'(out_pix), int'(prev_pix));
            end
            if (rd_en) begin
                check_eq("rd_room", int'((m_cnt + m_infl - int'(pop_n)) < 2), 1);
            end
            if (abort) begin
                m_cnt  = 0;
                m_infl = 0;
            end else begin
                m_cnt  = m_cnt + m_infl - int'(pop_n);
                m_infl = int'(rd_en);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_pix   = out_pix;
        prev_abort = abort;
    end

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int base;
        bit got;
        base = done_cnt;
        got  = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(posedge clk); #1;
            if (done_cnt > base) got = 1'b1;
        end
        check_eq({tag, "_done_seen"}, int'(got), 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rd_en", int'(rd_en), 0);
        check_eq("rst_rd_addr", int'(rd_addr), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_pix", int'(out_pix), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Frame 1: constant 100 in both images, ready held high, stray start mid-run
        mode      = M_CONST;
        exp_idx   = 0;
        out_ready = 1'b1;
        start_frame();
        repeat (100) @(posedge clk);
        #1;
        check_eq("f1_busy", int'(busy), 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(20000, "f1");
        check_eq("f1_done_cycle", done_c, NPIX + 3);
        check_eq("f1_outputs", exp_idx, NPIX);
        repeat (20) @(posedge clk);
        #1;
        check_eq("f1_done_pulses", done_cnt, 1);
        check_eq("f1_busy_after", int'(busy), 0);
        check_eq("f1_no_extra", exp_idx, NPIX);

        // Frame 2: ramp pattern, random backpressure, abort at address 5000
        mode      = M_RAMP;
        exp_idx   = 0;
        m_cnt     = 0;
        m_infl    = 0;
        chk_stall = 1'b1;
        base_done = done_cnt;
        start_frame();
        found = 1'b0;
        for (int i = 0; i < 30000 && !found; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (rd_addr == 14'd5000) begin
                abort = 1'b1;
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check_eq("f2_reached_5000", int'(found), 1);
        @(posedge clk); #1;
        abort     = 1'b0;
        chk_stall = 1'b0;
        check_eq("f2_progress", int'(exp_idx >= 4998), 1);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_rd_addr", int'(rd_addr), 0);
        check_eq("abort_valid", int'(out_valid), 0);
        saved_idx = exp_idx;
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_no_output", exp_idx, saved_idx);
        check_eq("abort_no_done", done_cnt, base_done);

        // Frame 3: mixed pattern restarted after abort; reset during drain
        mode      = M_MIX;
        exp_idx   = 0;
        out_ready = 1'b1;
        start_frame();
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(posedge clk); #1;
            if (rd_en && rd_addr == 14'(NPIX - 1)) found = 1'b1;
        end
        check_eq("f3_last_read", int'(found), 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("f3_drain_busy", int'(busy), 1);
        @(posedge clk); #1;
        check_eq("f3_progress", int'(exp_idx >= NPIX - 3), 1);
        check_eq("f3_stalled_valid", int'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valid", int'(out_valid), 0);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_rd_addr", int'(rd_addr), 0);
        check_eq("mid_rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Frame 4: clean mixed-pattern frame after reset
        exp_idx   = 0;
        out_ready = 1'b1;
        start_frame();
        wait_done(20000, "f4");
        check_eq("f4_done_cycle", done_c, NPIX + 3);
        check_eq("f4_outputs", exp_idx, NPIX);
        check_eq("total_done_pulses", done_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
